// File: rtl/bg_layer_fetcher.sv
// rtl/bg_layer_fetcher.sv - multi-layer background tile fetcher with round-robin SRAM arbitration
// Optional macro TILE_FLIP_EN: honour the char-word VF/HF tile flip bits.
module bg_layer_fetcher #(
  parameter int                NUM_LAYERS  = 4,
  parameter int                ADDR_W      = 18,
  parameter logic [ADDR_W-1:0] MAP_BASE    = 18'h02000,
  parameter logic [ADDR_W-1:0] MAP_STRIDE  = 18'h01000,
  parameter logic [ADDR_W-1:0] TILE_BASE   = 18'h00000,
  parameter int                LINE_PIXELS = 320
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    lineStart,
  input  logic [8:0]              vPos,
  input  logic [9*NUM_LAYERS-1:0] pan,
  input  logic [NUM_LAYERS-1:0]   layerEnable,
  output logic                    ram_req,
  output logic [ADDR_W-1:0]       ram_addr,
  input  logic                    ram_ack,
  input  logic [15:0]             ram_din,
  output logic [NUM_LAYERS-1:0]   pix_valid,
  input  logic [NUM_LAYERS-1:0]   pix_ready,
  output logic [4*NUM_LAYERS-1:0] pix_idx,
  output logic [3*NUM_LAYERS-1:0] pix_pal,
  output logic                    lineDone,
  output logic                    busy
);
  localparam int LW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

  typedef enum logic [2:0] {S_IDLE, S_CHAR, S_TLO, S_THI, S_SHIFT, S_DONE} state_t;

  state_t          state     [NUM_LAYERS];
  state_t          state_nxt [NUM_LAYERS];
  logic [5:0]      col       [NUM_LAYERS];
  logic [9:0]      emitted   [NUM_LAYERS];
  logic [2:0]      skip      [NUM_LAYERS];
  logic [2:0]      nib       [NUM_LAYERS];
  logic [2:0]      pal       [NUM_LAYERS];
  logic [8:0]      tile      [NUM_LAYERS];
  logic [2:0]      row_sel   [NUM_LAYERS];
  logic [31:0]     shreg     [NUM_LAYERS];
  logic [ADDR_W-1:0] layer_addr [NUM_LAYERS];
`ifdef TILE_FLIP_EN
  logic            vflip     [NUM_LAYERS];
  logic            hflip     [NUM_LAYERS];
`endif

  logic [8:0]            vpos;
  logic [LW-1:0]         owner, last;
  logic [NUM_LAYERS-1:0] ack_for, consume, want;
  logic                  hi_found, lo_found;
  logic [LW-1:0]         hi_idx, lo_idx, grant_idx;
  logic                  all_done_nxt, live;
  logic                  unused_char_bits;

  assign unused_char_bits = ^ram_din[15:12];

`ifdef TILE_FLIP_EN
  function automatic logic [31:0] nib_rev(input logic [31:0] w);
    logic [31:0] r;
    for (int i = 0; i < 8; i++) r[4*i +: 4] = w[28-4*i +: 4];
    return r;
  endfunction
`endif

  // Per-layer next state; lineStart overrides everything, including a same-cycle ack.
  always_comb begin
    for (int l = 0; l < NUM_LAYERS; l++) begin
      ack_for[l]   = ram_req && ram_ack && (owner == LW'(l));
      consume[l]   = (state[l] == S_SHIFT) && ((skip[l] != 3'd0) || pix_ready[l]);
      want[l]      = (state[l] == S_CHAR) || (state[l] == S_TLO) || (state[l] == S_THI);
      state_nxt[l] = state[l];
      if (lineStart) begin
        state_nxt[l] = layerEnable[l] ? S_CHAR : S_DONE;
      end else begin
        case (state[l])
          S_CHAR:  if (ack_for[l]) state_nxt[l] = S_TLO;
          S_TLO:   if (ack_for[l]) state_nxt[l] = S_THI;
          S_THI:   if (ack_for[l]) state_nxt[l] = S_SHIFT;
          S_SHIFT: if (consume[l]) begin
            if ((skip[l] == 3'd0) && (emitted[l] == 10'(LINE_PIXELS - 1))) state_nxt[l] = S_DONE;
            else if (nib[l] == 3'd7)                                         state_nxt[l] = S_CHAR;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    all_done_nxt = 1'b1;
    pix_valid    = '0;
    pix_idx      = '0;
    pix_pal      = '0;
    for (int l = 0; l < NUM_LAYERS; l++) begin
      if (state_nxt[l] != S_DONE) all_done_nxt = 1'b0;
      pix_valid[l]     = (state[l] == S_SHIFT) && (skip[l] == 3'd0);
      pix_idx[4*l +: 4] = shreg[l][31:28];
      pix_pal[3*l +: 3] = pal[l];
`ifdef TILE_FLIP_EN
      row_sel[l] = vflip[l] ? ~vpos[2:0] : vpos[2:0];
`else
      row_sel[l] = vpos[2:0];
`endif
      if (state[l] == S_CHAR)
        layer_addr[l] = MAP_BASE + ADDR_W'(l) * MAP_STRIDE + ADDR_W'({vpos[8:3], col[l]});
      else
        layer_addr[l] = TILE_BASE + ADDR_W'({tile[l], row_sel[l], (state[l] == S_THI)});
    end
  end

  // Round-robin: the lowest requester above the last grant wins, else the lowest overall.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int j = NUM_LAYERS - 1; j >= 0; j--) begin
      if (want[j]) begin
        if (LW'(j) > last) begin
          hi_found = 1'b1;
          hi_idx   = LW'(j);
        end
        lo_found = 1'b1;
        lo_idx   = LW'(j);
      end
    end
    grant_idx = hi_found ? hi_idx : lo_idx;
  end

  assign live = lineStart || (busy && !lineDone);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int l = 0; l < NUM_LAYERS; l++) begin
        state[l]   <= S_IDLE;
        col[l]     <= '0;
        emitted[l] <= '0;
        skip[l]    <= '0;
        nib[l]     <= '0;
        pal[l]     <= '0;
        tile[l]    <= '0;
        shreg[l]   <= '0;
`ifdef TILE_FLIP_EN
        vflip[l]   <= 1'b0;
        hflip[l]   <= 1'b0;
`endif
      end
      vpos     <= '0;
      owner    <= '0;
      last     <= LW'(NUM_LAYERS - 1);
      ram_req  <= 1'b0;
      ram_addr <= '0;
      lineDone <= 1'b0;
      busy     <= 1'b0;
    end else begin
      for (int l = 0; l < NUM_LAYERS; l++) state[l] <= state_nxt[l];
      lineDone <= live && all_done_nxt;
      busy     <= live;
      if (lineStart) begin
        vpos    <= vPos;
        ram_req <= 1'b0;
        for (int l = 0; l < NUM_LAYERS; l++) begin
          col[l]     <= pan[9*l+3 +: 6];
          skip[l]    <= pan[9*l +: 3];
          emitted[l] <= '0;
          nib[l]     <= '0;
        end
      end else begin
        if (ram_req) begin
          if (ram_ack) ram_req <= 1'b0;
        end else if (lo_found) begin
          ram_req  <= 1'b1;
          ram_addr <= layer_addr[grant_idx];
          owner    <= grant_idx;
          last     <= grant_idx;
        end
        for (int l = 0; l < NUM_LAYERS; l++) begin
          if (ack_for[l]) begin
            case (state[l])
              S_CHAR: begin
                pal[l]  <= ram_din[11:9];
                tile[l] <= ram_din[8:0];
`ifdef TILE_FLIP_EN
                vflip[l] <= ram_din[15];
                hflip[l] <= ram_din[14];
`endif
              end
              S_TLO: shreg[l][31:16] <= ram_din;
              S_THI: begin
`ifdef TILE_FLIP_EN
                shreg[l] <= hflip[l] ? nib_rev({shreg[l][31:16], ram_din}) : {shreg[l][31:16], ram_din};
`else
                shreg[l] <= {shreg[l][31:16], ram_din};
`endif
                nib[l] <= '0;
              end
              default: ;
            endcase
          end
          if (consume[l]) begin
            shreg[l] <= shreg[l] << 4;
            nib[l]   <= nib[l] + 3'd1;
            if (skip[l] != 3'd0) skip[l] <= skip[l] - 3'd1;
            else                 emitted[l] <= emitted[l] + 10'd1;
            if (nib[l] == 3'd7) col[l] <= col[l] + 6'd1;
          end
        end
      end
    end
  end
endmodule
